// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, EX redirect
// and multi-cycle data-memory hazards, runs the dmem handshake FSM and a watchdog.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ID_WIDTH = 5,
    parameter int unsigned TO_WIDTH     = 8,
    parameter int unsigned TIMEOUT      = 200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ID_WIDTH-1:0] rs1_ID,
    input  logic [REG_ID_WIDTH-1:0] rs2_ID,
    input  logic                    rs1_used_ID,
    input  logic                    rs2_used_ID,
    input  logic [REG_ID_WIDTH-1:0] rd_EX,
    input  logic                    load_EX,
    input  logic                    redirect_EX,
    input  logic                    mem_access_MEM,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    output logic                    dmem_req,
    output logic                    wen_PC,
    output logic                    wen_IF_ID,
    output logic                    wen_ID_EX,
    output logic                    wen_EX_MEM,
    output logic                    wen_MEM_WB,
    output logic                    flush_IF_ID,
    output logic                    flush_ID_EX,
    output logic                    flush_MEM_WB,
    output logic                    mem_timeout,
    output logic [31:0]             stall_cnt
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] TO_ONE  = TO_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_GNT  = 2'd1,
        WAIT_RESP = 2'd2
    } mem_state_t;

    mem_state_t          state;
    logic [TO_WIDTH-1:0] watchdog;

    logic waiting;
    logic mem_done;
    logic timeout_fire;
    logic mem_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Hazard detection
    always_comb begin
        waiting      = (state == WAIT_GNT) || (state == WAIT_RESP);
        mem_done     = (state == WAIT_RESP) && dmem_rvalid;
        timeout_fire = waiting && (watchdog == TO_LAST) && !mem_done;
        mem_stall    = mem_access_MEM && !mem_done && !timeout_fire;
        rs1_hit      = rs1_used_ID && (rs1_ID == rd_EX);
        rs2_hit      = rs2_used_ID && (rs2_ID == rd_EX);
        load_use     = load_EX && (rd_EX != '0) && (rs1_hit || rs2_hit);
    end

    // Prioritised enable/flush merge; reset forces everything to a bubble
    always_comb begin
        wen_PC       = 1'b1;
        wen_IF_ID    = 1'b1;
        wen_ID_EX    = 1'b1;
        wen_EX_MEM   = 1'b1;
        wen_MEM_WB   = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_MEM_WB = 1'b0;
        dmem_req     = 1'b0;

        unique case (state)
            IDLE:     dmem_req = mem_access_MEM;
            WAIT_GNT: dmem_req = 1'b1;
            default:  dmem_req = 1'b0;
        endcase

        if (rst) begin
            wen_PC       = 1'b0;
            wen_IF_ID    = 1'b0;
            wen_ID_EX    = 1'b0;
            wen_EX_MEM   = 1'b0;
            wen_MEM_WB   = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_MEM_WB = 1'b1;
            dmem_req     = 1'b0;
        end else if (mem_stall) begin
            // EX and ID freeze, so pending redirect/load-use survive the stall
            wen_PC       = 1'b0;
            wen_IF_ID    = 1'b0;
            wen_ID_EX    = 1'b0;
            wen_EX_MEM   = 1'b0;
            flush_MEM_WB = 1'b1;
        end else if (redirect_EX) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
        end else if (load_use) begin
            wen_PC       = 1'b0;
            wen_IF_ID    = 1'b0;
            flush_ID_EX  = 1'b1;
        end
    end

    // Memory FSM, watchdog, sticky timeout and stall counter.
    // The issue cycle counts toward the watchdog budget, hence the load of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            watchdog    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (!wen_PC) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (timeout_fire) begin
                mem_timeout <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (mem_access_MEM) begin
                        state    <= dmem_gnt ? WAIT_RESP : WAIT_GNT;
                        watchdog <= TO_ONE;
                    end else begin
                        watchdog <= '0;
                    end
                end
                WAIT_GNT: begin
                    if (timeout_fire) begin
                        state    <= IDLE;
                        watchdog <= '0;
                    end else begin
                        watchdog <= watchdog + TO_ONE;
                        if (dmem_gnt) begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_done || timeout_fire) begin
                        state    <= IDLE;
                        watchdog <= '0;
                    end else begin
                        watchdog <= watchdog + TO_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    watchdog <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline registers: PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Merges three hazard sources into one per-register write-enable and flush set:
  - load-use hazard detected in ID;
  - control redirect from EX;
  - multi-cycle data-memory access in MEM, which runs a req/gnt/rvalid handshake FSM with a watchdog.
- Also keeps a stall performance counter.

Parameters:
REG_ID_WIDTH, 5, width of register index fields
TO_WIDTH, 8, width of the memory watchdog counter
TIMEOUT, 200, cycles spent in WAIT_GNT plus WAIT_RESP before the access is aborted (must be < 2^TO_WIDTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
rs1_ID  in  REG_ID_WIDTH  source reg 1 of the ID instruction
rs2_ID  in  REG_ID_WIDTH  source reg 2 of the ID instruction
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
rd_EX  in  REG_ID_WIDTH  destination reg of the EX instruction
load_EX  in  1  EX instruction is a valid load
redirect_EX  in  1  EX resolved a taken branch or jump
mem_access_MEM  in  1  MEM stage holds a valid load or store
dmem_gnt  in  1  data memory accepted the request
dmem_rvalid  in  1  data memory completed the access
dmem_req  out  1  request to data memory
wen_PC, wen_IF_ID, wen_ID_EX, wen_EX_MEM, wen_MEM_WB  out  1 each  register load enable
flush_IF_ID, flush_ID_EX, flush_MEM_WB  out  1 each  register loads a bubble next edge; overrides wen
mem_timeout  out  1  sticky watchdog error flag
stall_cnt  out  32  count of cycles with wen_PC=0

Behaviour:
- All wen/flush/dmem_req outputs are combinational from the current FSM state and the inputs. mem_timeout and stall_cnt are registered.
- While rst=1:
  - all wen=0, all flush=1, dmem_req=0;
  - on the edge: state<=IDLE, watchdog<=0, mem_timeout<=0, stall_cnt<=0.
- Reset mid-access abandons the transaction; no completion is expected.
- Memory FSM states: IDLE, WAIT_GNT, WAIT_RESP.
  - IDLE: dmem_req=mem_access_MEM. If mem_access_MEM and dmem_gnt go to WAIT_RESP; if mem_access_MEM and !dmem_gnt go to WAIT_GNT.
  - WAIT_GNT: dmem_req=1. On dmem_gnt go to WAIT_RESP.
  - WAIT_RESP: dmem_req=0. On dmem_rvalid go to IDLE.
  - dmem_rvalid is ignored outside WAIT_RESP. Minimum access latency is therefore 2 cycles (gnt, then rvalid).
- Watchdog:
  - Counts each cycle spent in WAIT_GNT or WAIT_RESP; cleared in IDLE.
  - When the count equals TIMEOUT-1 and no completion occurs that cycle: set mem_timeout, go to IDLE, treat the access as complete that cycle.
- mem_stall = mem_access_MEM && !(state==WAIT_RESP && dmem_rvalid) && !timeout_fire.
- load_use = load_EX && rd_EX!=0 && ((rs1_used_ID && rs1_ID==rd_EX) || (rs2_used_ID && rs2_ID==rd_EX)).
- Output priority (highest first):
  - mem_stall: wen_PC = wen_IF_ID = wen_ID_EX = wen_EX_MEM = 0; flush_MEM_WB=1; other flushes 0. A concurrent redirect_EX or load_use is held, not lost, because EX and ID are frozen; it is acted on in the first non-stall cycle.
  - redirect_EX: all wen=1; flush_IF_ID=1, flush_ID_EX=1. Load-use is ignored because the ID instruction is squashed.
  - load_use: wen_PC=0, wen_IF_ID=0; flush_ID_EX=1 (one bubble); EX_MEM and MEM_WB advance. Exactly one bubble cycle per load-use, since the load leaves EX next cycle.
  - none: all wen=1, all flush=0.
- stall_cnt increments on each non-reset cycle with wen_PC=0, and wraps at 2^32.

Test Plan:
- Free-run: mem_access_MEM=0, no hazards for 10 cycles -> all wen=1, all flush=0, dmem_req=0, stall_cnt stays 0.
- Load-use: load_EX=1, rd_EX=5, rs2_ID=5, rs2_used_ID=1 for 1 cycle -> wen_PC=0, wen_IF_ID=0, flush_ID_EX=1 that cycle only; stall_cnt=1. Repeat with rd_EX=0 -> no stall.
- Memory handshake: mem_access_MEM=1, gnt after 3 cycles, rvalid 2 cycles later.
  - States: IDLE -> WAIT_GNT (dmem_req=1 for 4 cycles) -> WAIT_RESP.
  - wen_EX_MEM=0 and flush_MEM_WB=1 for 5 cycles; the rvalid cycle shows all wen=1; stall_cnt=5.
- Redirect during mem stall: redirect_EX=1 held across a 3-cycle memory stall -> no flush_IF_ID during the stall; flush_IF_ID=flush_ID_EX=1 in the release cycle.
- Timeout with TIMEOUT=4 and dmem_gnt stuck 0 -> dmem_req high 4 cycles, stall released on the 4th, mem_timeout=1 sticky, FSM back in IDLE.
- Reset mid-access: assert rst in WAIT_RESP -> next cycle state IDLE, dmem_req=0, mem_timeout=0, stall_cnt=0; a late dmem_rvalid is ignored.
